quiz_round_controller: RTL and testbench

Sequences one answer round of the quiz buzzer system. Arbitrates four player buzzers and runs the per-second answer countdown. Detects early-press fouls. Its count_out and error_flag outputs drive the dynamic-scan display's DataIn and ErrorFlag inputs directly. Runs on the board 50 MHz clock alongside the display.

---
 rtl/quiz_round_controller_if.sv | 21 ++
 rtl/quiz_round_controller.sv | 147 ++++++++++++++
 tb/tb_quiz_round_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/quiz_round_controller_if.sv
// Signal bundle between the quiz host/player panel and the round controller.
// The master side owns the buttons; the slave side (the controller) owns the display/result outputs.
interface quiz_round_controller_if;
  logic       host_start;
  logic       host_clear;
  logic [3:0] buzz;
  logic [9:0] count_out;
  logic       error_flag;
  logic [1:0] winner;
  logic       winner_valid;

  modport master (
    output host_start, host_clear, buzz,
    input  count_out, error_flag, winner, winner_valid
  );

  modport slave (
    input  host_start, host_clear, buzz,
    output count_out, error_flag, winner, winner_valid
  );
endinterface

// File: rtl/quiz_round_controller.sv
// One answer round of the quiz buzzer: button conditioning, buzz arbitration,
// per-second countdown and early-press foul detection feeding the scan display.
module quiz_round_controller #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ANSWER_TIME = 30
) (
  input  logic                  clk_50M,
  input  logic                  rst_n,
  quiz_round_controller_if.slave bus
);

  localparam int unsigned PRESC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [9:0]         COUNT_INIT = 10'(ANSWER_TIME);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_LOCK    = 3'd2,
    S_FOUL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  // Button bit layout: [5] host_clear, [4] host_start, [3:0] buzz.
  logic [5:0] btn_raw;
  logic [5:0] btn_meta;
  logic [5:0] btn_sync;
  logic [5:0] btn_prev;
  logic [5:0] btn_rise;

  assign btn_raw = {bus.host_clear, bus.host_start, bus.buzz};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  // Resetting to all 1s makes a button held through reset look already-pressed.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '1;
      btn_sync <= '1;
      btn_prev <= '1;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign btn_rise = btn_sync & ~btn_prev;

  logic       clear_rise;
  logic       start_rise;
  logic [3:0] buzz_rise;
  logic       buzz_any;
  logic [1:0] buzz_idx;

  assign clear_rise = btn_rise[5];
  assign start_rise = btn_rise[4];
  assign buzz_rise  = btn_rise[3:0];
  assign buzz_any   = |buzz_rise;

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    buzz_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (buzz_rise[i]) buzz_idx = 2'(i);
    end
  end

  state_t             state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [9:0]         count_q;
  logic               error_q;
  logic [1:0]         winner_q;
  logic               valid_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      count_q  <= COUNT_INIT;
      error_q  <= 1'b0;
      winner_q <= 2'd0;
      valid_q  <= 1'b0;
    end else if (clear_rise) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      count_q  <= COUNT_INIT;
      error_q  <= 1'b0;
      winner_q <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          count_q <= COUNT_INIT;
          if (buzz_any) begin
            state_q  <= S_FOUL;
            winner_q <= buzz_idx;
            valid_q  <= 1'b1;
            error_q  <= 1'b1;
          end else if (start_rise) begin
            state_q <= S_RUN;
            presc_q <= '0;
          end
        end

        S_RUN: begin
          if (buzz_any) begin
            // Buzz beats a coinciding tick: the displayed time freezes as-is.
            state_q  <= S_LOCK;
            winner_q <= buzz_idx;
            valid_q  <= 1'b1;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            if (count_q <= 10'd1) begin
              count_q <= 10'd0;
              state_q <= S_TIMEOUT;
            end else begin
              count_q <= count_q - 10'd1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end

        S_LOCK, S_FOUL, S_TIMEOUT: begin
          // Result stays on display until the host clears the round.
        end

        default: begin
          state_q  <= S_IDLE;
          presc_q  <= '0;
          count_q  <= COUNT_INIT;
          error_q  <= 1'b0;
          winner_q <= 2'd0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count_out    = count_q;
  assign bus.error_flag   = error_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = valid_q;

endmodule

// File: tb/tb_quiz_round_controller.sv
// Directed bench for quiz_round_controller with TICK_DIV=4, ANSWER_TIME=5.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_quiz_round_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  quiz_round_controller_if bus_if ();

  quiz_round_controller #(
    .TICK_DIV   (4),
    .ANSWER_TIME(5)
  ) dut (
    .clk_50M(clk),
    .rst_n  (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pulse_clear();
    bus_if.host_clear = 1'b1;
    wait_neg(1);
    bus_if.host_clear = 1'b0;
    wait_neg(2);
  endtask

  task automatic pulse_start();
    bus_if.host_start = 1'b1;
    wait_neg(1);
    bus_if.host_start = 1'b0;
    wait_neg(2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    bus_if.host_start = 1'b0;
    bus_if.host_clear = 1'b0;
    bus_if.buzz       = 4'b0000;
    wait_neg(2);
    check("reset_count", bus_if.count_out, 5);
    check("reset_error", bus_if.error_flag, 0);
    check("reset_winner", bus_if.winner, 0);
    check("reset_valid", bus_if.winner_valid, 0);
    rst_n = 1'b1;
    wait_neg(4);
    check("idle_count", bus_if.count_out, 5);

    // Countdown: RUN entered at edge 3 after the press, then one step per 4 clk.
    pulse_start();
    check("run_entry_count", bus_if.count_out, 5);
    wait_neg(3);
    check("run_pre_tick", bus_if.count_out, 5);
    wait_neg(1);
    check("run_count4", bus_if.count_out, 4);
    wait_neg(4);
    check("run_count3", bus_if.count_out, 3);
    wait_neg(4);
    check("run_count2", bus_if.count_out, 2);
    wait_neg(4);
    check("run_count1", bus_if.count_out, 1);
    wait_neg(4);
    check("run_count0", bus_if.count_out, 0);
    wait_neg(12);
    check("timeout_hold", bus_if.count_out, 0);
    check("timeout_error", bus_if.error_flag, 0);
    check("timeout_valid", bus_if.winner_valid, 0);
    bus_if.buzz = 4'b0001;
    wait_neg(4);
    check("timeout_buzz_ignored", bus_if.winner_valid, 0);
    bus_if.buzz = 4'b0000;
    wait_neg(2);

    // Normal lock at count 3.
    pulse_clear();
    check("clear_after_timeout", bus_if.count_out, 5);
    pulse_start();
    wait_neg(8);
    check("lock_pre_count", bus_if.count_out, 3);
    bus_if.buzz = 4'b0100;
    wait_neg(2);
    check("lock_latency_valid", bus_if.winner_valid, 0);
    wait_neg(1);
    check("lock_winner", bus_if.winner, 2);
    check("lock_valid", bus_if.winner_valid, 1);
    check("lock_count", bus_if.count_out, 3);
    check("lock_error", bus_if.error_flag, 0);
    wait_neg(24);
    check("lock_frozen", bus_if.count_out, 3);
    bus_if.buzz = 4'b0101;
    wait_neg(4);
    check("lock_buzz0_ignored", bus_if.winner, 2);
    bus_if.buzz = 4'b0000;
    wait_neg(2);

    // Foul in IDLE with two simultaneous presses: lowest index wins.
    pulse_clear();
    check("clear_after_lock_valid", bus_if.winner_valid, 0);
    check("clear_after_lock_count", bus_if.count_out, 5);
    bus_if.buzz = 4'b1010;
    wait_neg(1);
    bus_if.buzz = 4'b0000;
    wait_neg(2);
    check("foul_error", bus_if.error_flag, 1);
    check("foul_winner", bus_if.winner, 1);
    check("foul_valid", bus_if.winner_valid, 1);
    check("foul_count", bus_if.count_out, 5);
    bus_if.buzz = 4'b0001;
    wait_neg(4);
    check("foul_buzz_ignored", bus_if.winner, 1);
    bus_if.buzz = 4'b0000;
    wait_neg(2);
    pulse_clear();
    check("foul_clear_error", bus_if.error_flag, 0);
    check("foul_clear_valid", bus_if.winner_valid, 0);
    check("foul_clear_count", bus_if.count_out, 5);
    pulse_start();
    check("start_after_foul_clear", bus_if.winner_valid, 0);
    wait_neg(4);
    check("start_after_foul_tick", bus_if.count_out, 4);

    // Buzz edge coinciding with the 4->3 tick: count keeps 4.
    pulse_clear();
    pulse_start();
    wait_neg(5);
    check("collide_pre_count", bus_if.count_out, 4);
    bus_if.buzz = 4'b0001;
    wait_neg(3);
    check("collide_count", bus_if.count_out, 4);
    check("collide_winner", bus_if.winner, 0);
    check("collide_valid", bus_if.winner_valid, 1);
    wait_neg(8);
    check("collide_frozen", bus_if.count_out, 4);
    bus_if.buzz = 4'b0000;
    wait_neg(2);

    // host_clear and buzz together in RUN: clear wins.
    pulse_clear();
    pulse_start();
    wait_neg(2);
    bus_if.host_clear = 1'b1;
    bus_if.buzz       = 4'b1000;
    wait_neg(1);
    bus_if.host_clear = 1'b0;
    bus_if.buzz       = 4'b0000;
    wait_neg(2);
    check("clear_buzz_valid", bus_if.winner_valid, 0);
    check("clear_buzz_count", bus_if.count_out, 5);
    wait_neg(8);
    check("clear_buzz_no_foul", bus_if.error_flag, 0);
    check("clear_buzz_idle_count", bus_if.count_out, 5);

    // Asynchronous reset mid-round, buzz[3] held through release.
    pulse_start();
    wait_neg(12);
    check("mid_reset_pre_count", bus_if.count_out, 2);
    bus_if.buzz = 4'b1000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_count", bus_if.count_out, 5);
    check("async_reset_valid", bus_if.winner_valid, 0);
    check("async_reset_error", bus_if.error_flag, 0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(6);
    check("held_buzz_no_foul", bus_if.error_flag, 0);
    check("held_buzz_no_valid", bus_if.winner_valid, 0);
    check("held_buzz_count", bus_if.count_out, 5);
    bus_if.buzz = 4'b0000;
    wait_neg(2);
    bus_if.buzz = 4'b1000;
    wait_neg(3);
    check("repress_foul_error", bus_if.error_flag, 1);
    check("repress_foul_winner", bus_if.winner, 3);
    check("repress_foul_valid", bus_if.winner_valid, 1);
    bus_if.buzz = 4'b0000;
    wait_neg(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
